// File: rtl/pipeline_reg_chain.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : pipeline_reg_chain
//  Description : DEPTH-stage valid/ready register chain carrying LANES lanes
//                of WIDTH bits per beat. The ready path is combinational from
//                out_ready back to in_ready, so a full pipe that is moving
//                sustains one beat per cycle without bubbles. A synchronous
//                flush discards every in-flight beat. The block also keeps an
//                occupancy count and a saturating output stall counter.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   clock, all state updates on its rising edge
//    reset_n      in   asynchronous active-low reset
//    in_valid     in   in_data holds a beat
//    in_ready     out  chain accepts a beat this cycle
//    in_data      in   LANES*WIDTH, lane k at [k*WIDTH +: WIDTH]
//    out_valid    out  out_data holds a beat
//    out_ready    in   consumer takes the beat this cycle
//    out_data     out  LANES*WIDTH, last-stage data register
//    flush        in   synchronous discard of all in-flight beats
//    stat_clr     in   synchronous clear of stall_count
//    occupancy    out  number of valid stages
//    stall_count  out  16-bit saturating count of back-pressured cycles
// ============================================================================
module pipeline_reg_chain #(
    parameter int WIDTH = 32,
    parameter int LANES = 8,
    parameter int DEPTH = 4     // legal range 1..16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES*WIDTH-1:0]       in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*WIDTH-1:0]       out_data,
    input  logic                         flush,
    input  logic                         stat_clr,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic [15:0]                  stall_count
);

    localparam int          DATA_W    = LANES * WIDTH;
    localparam int          OCC_W     = $clog2(DEPTH + 1);
    localparam logic [15:0] STALL_MAX = 16'hFFFF;

    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  valid_d;
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [OCC_W-1:0]  occupancy_q;
    logic [OCC_W-1:0]  occupancy_d;
    logic [15:0]       stall_count_q;
    logic [15:0]       stall_count_d;

    // w_ready[i] is the ready seen by stage i; w_ready[DEPTH] is out_ready.
    logic [DEPTH:0]    w_ready;
    logic              w_run;

    // Stage i is ready when it is empty or everything downstream can move.
    // Built as a running OR from the output end so there is no
    // self-referencing combinational vector.
    always_comb begin
        w_run          = out_ready;
        w_ready        = '0;
        w_ready[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_run      = w_run | ~valid_q[i];
            w_ready[i] = w_run;
        end
    end

    // Next-state for the stage registers. A stage loads from its upstream
    // neighbour whenever it is ready, even if that neighbour is empty; this is
    // how bubbles collapse. Flush wins over every load and leaves the data
    // registers untouched.
    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < DEPTH; i++) begin
            data_d[i] = data_q[i];
        end

        if (flush) begin
            valid_d = '0;
        end else begin
            if (w_ready[0]) begin
                valid_d[0] = in_valid;
                data_d[0]  = in_data;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (w_ready[i]) begin
                    valid_d[i] = valid_q[i-1];
                    data_d[i]  = data_q[i-1];
                end
            end
        end
    end

    // Occupancy is registered alongside the valid bits so it always matches
    // the popcount of the stage valids currently held.
    always_comb begin
        occupancy_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy_d = occupancy_d + OCC_W'(valid_d[i]);
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (stat_clr) begin
            stall_count_d = '0;
        end else if (valid_q[DEPTH-1] && !out_ready && !flush &&
                     (stall_count_q != STALL_MAX)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
            occupancy_q   <= '0;
            stall_count_q <= '0;
        end else begin
            valid_q       <= valid_d;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
            end
            occupancy_q   <= occupancy_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign in_ready    = w_ready[0] & ~flush;
    assign out_valid   = valid_q[DEPTH-1] & ~flush;
    assign out_data    = data_q[DEPTH-1];
    assign occupancy   = occupancy_q;
    assign stall_count = stall_count_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_reg_chain.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_pipeline_reg_chain
//  Description : Directed self-checking bench for pipeline_reg_chain with
//                DEPTH=4, LANES=8, WIDTH=32.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipeline_reg_chain;

    localparam int WIDTH = 32;
    localparam int LANES = 8;
    localparam int DEPTH = 4;
    localparam int DW    = LANES * WIDTH;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          flush;
    logic          stat_clr;
    logic [2:0]    occupancy;
    logic [15:0]   stall_count;

    int checks = 0;
    int errors = 0;

    pipeline_reg_chain #(
        .WIDTH (WIDTH),
        .LANES (LANES),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .flush       (flush),
        .stat_clr    (stat_clr),
        .occupancy   (occupancy),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Every lane distinct so lane swaps or truncation are visible.
    function automatic logic [DW-1:0] beat(input int v);
        logic [DW-1:0] b;
        for (int k = 0; k < LANES; k++) begin
            b[k*WIDTH +: WIDTH] = (32'(v) << 8) | 32'(k);
        end
        return b;
    endfunction

    // Inputs change 1 ns after the rising edge; checks sample 3 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        stat_clr  = 1'b0;
        #1;
        reset_n   = 1'b0;
        in_valid  = 1'b1;
        in_data   = beat(8'hEE);
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_stall", stall_count, 0);
        check("rst_in_ready", in_ready, 1);
        tick();
        tick();
        check("rst_no_xfer_occ", occupancy, 0);
        check("rst_no_xfer_valid", out_valid, 0);
        reset_n  = 1'b1;
        in_valid = 1'b0;

        // Streaming, out_ready held high.
        for (int t = 0; t <= 20; t++) begin
            in_valid  = (t < 16);
            in_data   = beat(t + 1);
            out_ready = 1'b1;
            #2;
            if (t < 16) check("stream_in_ready", in_ready, 1);
            check("stream_out_valid", out_valid, (t >= 4 && t <= 19));
            if (t >= 4 && t <= 19) check("stream_out_data", out_data, beat(t - 3));
            tick();
        end
        in_valid = 1'b0;
        #2;
        check("stream_occ_end", occupancy, 0);
        tick();

        // Backpressure: fill with A..D, hold, then drain.
        for (int k = 0; k < 4; k++) begin
            in_valid  = 1'b1;
            in_data   = beat(8'hA0 + k);
            out_ready = 1'b0;
            #2;
            check("bp_fill_in_ready", in_ready, 1);
            tick();
        end
        for (int s = 0; s < 4; s++) begin
            in_valid = 1'b1;
            in_data  = beat(8'hA4);
            #2;
            check("bp_in_ready", in_ready, 0);
            check("bp_occupancy", occupancy, 4);
            check("bp_out_valid", out_valid, 1);
            check("bp_out_data_hold", out_data, beat(8'hA0));
            check("bp_stall", stall_count, 16'(s));
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            in_valid  = 1'b0;
            out_ready = 1'b1;
            #2;
            check("drain_out_valid", out_valid, 1);
            check("drain_out_data", out_data, beat(8'hA0 + k));
            check("drain_stall", stall_count, 4);
            tick();
        end
        #2;
        check("drain_empty_valid", out_valid, 0);
        check("drain_empty_occ", occupancy, 0);
        tick();

        // Simultaneous push and pop on a full pipe.
        for (int k = 0; k < 4; k++) begin
            in_valid  = 1'b1;
            in_data   = beat(8'h50 + k);
            out_ready = 1'b0;
            #2;
            tick();
        end
        in_valid  = 1'b1;
        in_data   = beat(8'h54);
        out_ready = 1'b1;
        #2;
        check("pp_in_ready", in_ready, 1);
        check("pp_out_data", out_data, beat(8'h50));
        check("pp_occ_before", occupancy, 4);
        tick();
        for (int k = 1; k <= 4; k++) begin
            in_valid = 1'b0;
            #2;
            if (k == 1) check("pp_occ_after", occupancy, 4);
            check("pp_drain_data", out_data, beat(8'h50 + k));
            tick();
        end
        #2;
        check("pp_empty_occ", occupancy, 0);
        tick();

        // Flush with three beats held and a concurrent input.
        for (int k = 0; k < 3; k++) begin
            in_valid  = 1'b1;
            in_data   = beat(8'h60 + k);
            out_ready = 1'b0;
            #2;
            tick();
        end
        in_valid = 1'b1;
        in_data  = beat(8'h63);
        flush    = 1'b1;
        #2;
        check("fl_occ_before", occupancy, 3);
        check("fl_in_ready", in_ready, 0);
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #2;
            check("fl_out_valid", out_valid, 0);
            check("fl_occupancy", occupancy, 0);
            tick();
        end

        // Flush a full pipe: output must be suppressed during the flush cycle.
        for (int k = 0; k < 4; k++) begin
            in_valid  = 1'b1;
            in_data   = beat(8'h70 + k);
            out_ready = 1'b0;
            #2;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b1;
        #2;
        check("flf_out_valid_sup", out_valid, 0);
        check("flf_stall", stall_count, 4);
        tick();
        flush = 1'b0;
        #2;
        check("flf_occ", occupancy, 0);
        check("flf_out_valid", out_valid, 0);
        tick();

        // Stall counter: clear-over-increment, long hold, saturation.
        for (int k = 0; k < 4; k++) begin
            in_valid  = 1'b1;
            in_data   = beat(8'hB0 + k);
            out_ready = 1'b0;
            #2;
            tick();
        end
        in_valid = 1'b0;
        stat_clr = 1'b1;
        #2;
        check("sc_before_clr", stall_count, 4);
        tick();
        stat_clr = 1'b0;
        #2;
        check("sc_clr_over_inc", stall_count, 0);
        tick();
        for (int i = 0; i < 65533; i++) begin
            tick();
        end
        #2;
        check("sc_fffe", stall_count, 16'hFFFE);
        check("sc_hold_data", out_data, beat(8'hB0));
        for (int i = 0; i < 3; i++) begin
            tick();
            #2;
            check("sc_saturate", stall_count, 16'hFFFF);
        end
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        #2;
        check("sc_clr_with_stall", stall_count, 0);
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        #2;
        check("sc_drained_occ", occupancy, 0);
        tick();

        // Asynchronous reset mid-stream, then resume.
        for (int t = 0; t < 6; t++) begin
            in_valid  = 1'b1;
            in_data   = beat(8'hC0 + t);
            out_ready = 1'b1;
            #2;
            tick();
        end
        in_valid = 1'b0;
        #2;
        check("ar_pre_valid", out_valid, 1);
        check("ar_pre_occ", occupancy, 4);
        check("ar_pre_stall", stall_count, 1);
        reset_n = 1'b0;
        #1;
        check("ar_out_valid", out_valid, 0);
        check("ar_out_data", out_data, 0);
        check("ar_occupancy", occupancy, 0);
        check("ar_stall", stall_count, 0);
        reset_n  = 1'b1;
        in_valid = 1'b1;
        in_data  = beat(8'hD0);
        tick();
        for (int t = 1; t <= 8; t++) begin
            in_valid = (t < 4);
            in_data  = beat(8'hD0 + t);
            #2;
            if (t < 4) check("ar_resume_in_ready", in_ready, 1);
            check("ar_resume_valid", out_valid, (t >= 4 && t < 8));
            if (t >= 4 && t < 8) check("ar_resume_data", out_data, beat(8'hD0 + t - 4));
            if (t == 8) check("ar_resume_occ", occupancy, 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
